// File: rtl/sma_pkg.sv
// Shared types and width helpers for the streaming moving-average block.
package sma_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } sma_state_t;

  // Ceiling log2; exact for the power-of-two window sizes this block accepts.
  function automatic int log2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int sum_width_f(input int data_width, input int window_size);
    return data_width + log2_f(window_size);
  endfunction

  function automatic int count_width_f(input int window_size);
    return log2_f(window_size) + 1;
  endfunction

endpackage

// File: rtl/sma_stream_if.sv
// Sample stream in, window sum/average out; the slave modport is the averager's view.
interface sma_stream_if
  import sma_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int WINDOW_SIZE = 4
);

  localparam int SUM_WIDTH   = sum_width_f(DATA_WIDTH, WINDOW_SIZE);
  localparam int COUNT_WIDTH = count_width_f(WINDOW_SIZE);

  logic                   valid_i;
  logic [DATA_WIDTH-1:0]  data_i;
  logic                   clear_i;
  logic                   valid_o;
  logic [DATA_WIDTH-1:0]  average_o;
  logic [SUM_WIDTH-1:0]   sum_o;
  logic [COUNT_WIDTH-1:0] count_o;
  logic                   full_o;

  modport slave (
    input  valid_i, data_i, clear_i,
    output valid_o, average_o, sum_o, count_o, full_o
  );

  modport master (
    output valid_i, data_i, clear_i,
    input  valid_o, average_o, sum_o, count_o, full_o
  );

endinterface

// File: rtl/sma_ring_buffer.sv
// Window storage: one write port and an asynchronous read of the same slot,
// so the outgoing sample is available in the cycle it gets overwritten.
module sma_ring_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[addr_i] <= wr_data_i;
  end

  assign rd_data_o = r_mem[addr_i];

endmodule

// File: rtl/sma_stream.sv
// Streaming simple moving average over a power-of-two window, kept as a running sum.
module sma_stream
  import sma_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int WINDOW_SIZE = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  sma_stream_if.slave   bus
);

  localparam int LOG2W       = log2_f(WINDOW_SIZE);
  localparam int SUM_WIDTH   = sum_width_f(DATA_WIDTH, WINDOW_SIZE);
  localparam int COUNT_WIDTH = count_width_f(WINDOW_SIZE);

  sma_state_t             r_state, w_state_next;
  logic [SUM_WIDTH-1:0]   r_sum, w_sum_next;
  logic [COUNT_WIDTH-1:0] r_count, w_count_next;
  logic [LOG2W-1:0]       r_wr_ptr, w_wr_ptr_next;
  logic                   r_valid, w_valid_next;
  logic [DATA_WIDTH-1:0]  r_average;
  logic                   r_full;
  logic                   w_wr_en;
  logic [DATA_WIDTH-1:0]  w_oldest;
  logic [COUNT_WIDTH-1:0] w_count_inc;

  sma_ring_buffer #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (WINDOW_SIZE),
    .AW    (LOG2W)
  ) u_ring (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_en),
    .addr_i    (r_wr_ptr),
    .wr_data_i (bus.data_i),
    .rd_data_o (w_oldest)
  );

  assign w_count_inc = r_count + COUNT_WIDTH'(1);

  // Pointer width is exactly log2(window), so the increment wraps on its own.
  always_comb begin
    w_state_next  = r_state;
    w_sum_next    = r_sum;
    w_count_next  = r_count;
    w_wr_ptr_next = r_wr_ptr;
    w_valid_next  = 1'b0;
    w_wr_en       = 1'b0;
    if (bus.clear_i) begin
      w_state_next  = ST_FILL;
      w_sum_next    = '0;
      w_count_next  = '0;
      w_wr_ptr_next = '0;
    end else if (bus.valid_i) begin
      w_wr_en       = 1'b1;
      w_wr_ptr_next = r_wr_ptr + LOG2W'(1);
      case (r_state)
        ST_FILL: begin
          w_sum_next   = r_sum + SUM_WIDTH'(bus.data_i);
          w_count_next = w_count_inc;
          if (w_count_inc == COUNT_WIDTH'(WINDOW_SIZE)) begin
            w_state_next = ST_RUN;
            w_valid_next = 1'b1;
          end
        end
        ST_RUN: begin
          w_sum_next   = r_sum + SUM_WIDTH'(bus.data_i) - SUM_WIDTH'(w_oldest);
          w_valid_next = 1'b1;
        end
        default: w_state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_FILL;
      r_sum     <= '0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_valid   <= 1'b0;
      r_average <= '0;
      r_full    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sum     <= w_sum_next;
      r_count   <= w_count_next;
      r_wr_ptr  <= w_wr_ptr_next;
      r_valid   <= w_valid_next;
      r_average <= DATA_WIDTH'(w_sum_next >> LOG2W);
      r_full    <= (w_count_next == COUNT_WIDTH'(WINDOW_SIZE));
    end
  end

  assign bus.valid_o   = r_valid;
  assign bus.average_o = r_average;
  assign bus.sum_o     = r_sum;
  assign bus.count_o   = r_count;
  assign bus.full_o    = r_full;

endmodule

// File: doc/sma_stream.md
SMA_STREAM -- requirements
Module: sma_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, unsigned sample width in bits.
REQ-002 SHALL have parameter WINDOW_SIZE, default 4, averaging window depth; legal values are powers of two from 2 to 256.
REQ-003 SHALL have derived constant SUM_WIDTH = DATA_WIDTH + log2(WINDOW_SIZE), the running-sum width.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port valid_i, input, 1 bit: data_i holds a sample this cycle; there is no backpressure.
REQ-007 SHALL have port data_i, input, DATA_WIDTH bits: unsigned sample.
REQ-008 SHALL have port clear_i, input, 1 bit: synchronous window flush.
REQ-009 SHALL have port valid_o, output, 1 bit: single-cycle strobe marking a new full-window average.
REQ-010 SHALL have port average_o, output, DATA_WIDTH bits: latest window average.
REQ-011 SHALL have port sum_o, output, SUM_WIDTH bits: latest window sum.
REQ-012 SHALL have port count_o, output, log2(WINDOW_SIZE)+1 bits: samples currently held, saturating at WINDOW_SIZE.
REQ-013 SHALL have port full_o, output, 1 bit: high when count_o == WINDOW_SIZE.

Function
REQ-014 SHALL hold the last WINDOW_SIZE accepted samples in a circular buffer indexed by wr_ptr; wr_ptr wraps from WINDOW_SIZE-1 to 0.
REQ-015 SHALL have two states: FILL (count < WINDOW_SIZE) and RUN (count == WINDOW_SIZE); FILL goes to RUN on the accepted sample that brings count to WINDOW_SIZE; RUN goes to FILL only on clear_i or reset_i.
REQ-016 SHALL, for an accepted sample in FILL: sum <= sum + data_i, count <= count + 1, buffer[wr_ptr] <= data_i, wr_ptr advances.
REQ-017 SHALL, for an accepted sample in RUN: sum <= sum + data_i - buffer[wr_ptr], overwrite buffer[wr_ptr], advance wr_ptr, keep count saturated.
REQ-018 SHALL use running-sum arithmetic only; there is no re-summation of the buffer, and SUM_WIDTH guarantees the sum never overflows.
REQ-019 SHALL compute average_o = sum >> log2(WINDOW_SIZE), truncating toward zero, with no divider.
REQ-020 SHALL register all outputs; latency is 1 cycle, so a sample accepted in cycle N is reflected in sum_o, average_o and count_o in cycle N+1.
REQ-021 SHALL assert valid_o in cycle N+1 only if a sample was accepted in cycle N and the state after that sample is RUN; valid_o is otherwise low.
REQ-022 SHALL hold sum_o, average_o and count_o unchanged in cycles with valid_i low.
REQ-023 SHALL drive average_o and sum_o during FILL as the partial sum and the partial sum >> log2(WINDOW_SIZE), with valid_o low.
REQ-024 SHALL, on clear_i: next cycle sum, count, wr_ptr, average_o and valid_o are 0; the state is FILL; buffer contents are left stale; clear_i has priority over valid_i, so a simultaneous sample is discarded.
REQ-025 SHALL never read a stale buffer entry into the sum, since subtraction occurs only in RUN and every entry has been rewritten by then.

Reset
REQ-026 SHALL, on reset_i high at a clock edge: sum, count, wr_ptr, valid_o, average_o, sum_o and full_o go to 0 and the state goes to FILL; reset_i has priority over clear_i and valid_i.
REQ-027 SHALL not require reset of the buffer storage itself.
REQ-028 SHALL return to FILL on a reset mid-RUN and require WINDOW_SIZE new samples before the next valid_o.

Structure
REQ-029 SHALL place the log2 helper function and the SUM_WIDTH/count-width derivations in shared package sma_pkg.
REQ-030 SHALL implement storage in sub-module sma_ring_buffer (write port plus read-before-write at wr_ptr); the sum and control logic stays in sma_stream.

Verification (DATA_WIDTH=16, WINDOW_SIZE=4)
REQ-031 SHALL cover warm-up: samples 4, 8, 12, 16 on consecutive cycles -> valid_o first high the cycle after 16, sum_o=40, average_o=10; then sample 20 -> sum_o=56, average_o=14.
REQ-032 SHALL cover gaps: the same samples with valid_i low for 3 cycles between each -> identical sum_o/average_o sequence, valid_o once per accepted sample in RUN, outputs held during gaps.
REQ-033 SHALL cover saturation: five samples of 0xFFFF -> sum_o=0x3FFFC, average_o=0xFFFF, with no wrap.
REQ-034 SHALL cover clear with simultaneous valid: clear_i and valid_i together in RUN -> next cycle count_o=0, sum_o=0, valid_o=0, sample dropped; then 1, 2, 3, 6 -> average_o=3.
REQ-035 SHALL cover reset mid-run: reset_i pulsed after 6 samples -> all outputs 0; a further 3 samples leave valid_o low and full_o low.
REQ-036 SHALL cover truncation: samples 1, 1, 1, 2 -> sum_o=5, average_o=1.
